// File: rtl/pb_debouncer.sv
// pb_debouncer: counter-based push-button debouncer producing a clean registered level.
// Define PB_DEBOUNCER_SYNC_EN to insert a 2-flop synchronizer ahead of the qualifier.
module pb_debouncer #(
  parameter int STABLE_CYCLES = 100000,
  parameter int CNT_W = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_raw,
  output logic pb_debounced,
  output logic pb_busy
);
  typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} state_t;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(STABLE_CYCLES - 1);
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic pb_s, term, deb_nxt, busy_nxt;
`ifdef PB_DEBOUNCER_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk)
    if (!rst_n) sync <= '0;
    else sync <= {sync[0], pb_raw};
  assign pb_s = sync[1];
`else
  assign pb_s = pb_raw;
`endif
  assign term = cnt == TERM;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= S_LOW;
      cnt <= '0;
      pb_debounced <= 1'b0;
      pb_busy <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      pb_debounced <= deb_nxt;
      pb_busy <= busy_nxt;
    end
  // an opposite sample is checked before the terminal count so it always aborts
  always_comb begin
    state_nxt = S_LOW;
    cnt_nxt = '0;
    case (state)
      S_LOW: begin
        state_nxt = pb_s ? S_RISE : S_LOW;
        cnt_nxt = pb_s ? CNT_W'(1) : '0;
      end
      S_RISE: begin
        state_nxt = !pb_s ? S_LOW : term ? S_HIGH : S_RISE;
        cnt_nxt = (!pb_s || term) ? '0 : cnt + CNT_W'(1);
      end
      S_HIGH: begin
        state_nxt = pb_s ? S_HIGH : S_FALL;
        cnt_nxt = pb_s ? '0 : CNT_W'(1);
      end
      S_FALL: begin
        state_nxt = pb_s ? S_HIGH : term ? S_LOW : S_FALL;
        cnt_nxt = (pb_s || term) ? '0 : cnt + CNT_W'(1);
      end
      default: begin
        state_nxt = S_LOW;
        cnt_nxt = '0;
      end
    endcase
  end
  always_comb begin
    deb_nxt = state_nxt == S_HIGH || state_nxt == S_FALL;
    busy_nxt = state_nxt == S_RISE || state_nxt == S_FALL;
  end
endmodule

// File: tb/tb_pb_debouncer.sv
// tb_pb_debouncer: random and directed stimulus checked against a run-length reference model.
module tb_pb_debouncer;
  localparam int STABLE = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pb_raw = 1'b0;
  logic pb_debounced, pb_busy;
  int vectors = 0;
  int miscompares = 0;
  logic m_level = 1'b0;
  int m_run = 0;
  logic [1:0] m_sync = 2'b00;

  pb_debouncer #(.STABLE_CYCLES(STABLE), .CNT_W(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pb_raw(pb_raw),
    .pb_debounced(pb_debounced),
    .pb_busy(pb_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, obs, exp);
    end
  endtask

  // the level flips once STABLE consecutive samples disagree with it; any agreeing sample clears the run
  task automatic step(input logic raw, input logic rn);
    logic s;
    pb_raw = raw;
    rst_n = rn;
    @(posedge clk);
    #1;
`ifdef PB_DEBOUNCER_SYNC_EN
    s = m_sync[1];
    m_sync = {m_sync[0], raw};
`else
    s = raw;
`endif
    if (!rn) begin
      m_level = 1'b0;
      m_run = 0;
      m_sync = 2'b00;
    end else if (s == m_level) begin
      m_run = 0;
    end else begin
      m_run++;
      if (m_run == STABLE) begin
        m_level = s;
        m_run = 0;
      end
    end
    check("debounced", pb_debounced, m_level);
    check("busy", pb_busy, m_run != 0);
  endtask

  task automatic hold(input logic raw, input int n);
    for (int i = 0; i < n; i++) step(raw, 1'b1);
  endtask

  initial begin
    logic [7:0] bounce;
    bounce = 8'b1110_1111;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    hold(1'b0, 4);
    hold(1'b1, 10);
    hold(1'b0, 10);
    for (int i = 7; i >= 0; i--) step(bounce[i], 1'b1);
    hold(1'b1, 6);
    hold(1'b0, 3);
    hold(1'b1, 8);
    hold(1'b0, 10);
    hold(1'b1, 3);
    step(1'b1, 1'b0);
    hold(1'b1, 10);
    hold(1'b0, 10);
    for (int seg = 0; seg < 400; seg++) begin
      logic lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      if ($urandom_range(0, 49) == 0) step(lvl, 1'b0);
      else hold(lvl, len);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
